accum_sequencer: RTL

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_sequencer_pkg.sv | 12 +
 rtl/accum_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/accum_sequencer_pkg.sv
// Shared complex sample type and its zero value, used by the sequencer and its
// parent (which owns the accumulator).
package accum_sequencer_pkg;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } complex_t;

    localparam complex_t COMPLEX_ZERO = '{re: 32'h0, im: 32'h0};

endpackage

// File: rtl/accum_sequencer.sv
// Sequences one block of complex samples through an external accumulator:
// start pulse, cfg_len samples, stop pulse, then hands the result downstream.
module accum_sequencer
    import accum_sequencer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  complex_t         s_data,
    output logic             acc_start,
    output logic             acc_stop,
    output complex_t         acc_in,
    input  logic             acc_valid,
    input  complex_t         acc_out,
    output logic             m_valid,
    input  logic             m_ready,
    output complex_t         m_data,
    output logic             busy,
    output logic             err_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        STOP,
        DRAIN,
        HOLD
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    complex_t         m_data_next;
    complex_t         acc_in_next;
    logic             err_next;

    assign cmd_ready = (state_reg == IDLE);
    assign s_ready   = (state_reg == STREAM);

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        cnt_next    = cnt_reg;
        tmr_next    = tmr_reg;
        m_data_next = m_data;
        err_next    = err_timeout;
        acc_in_next = COMPLEX_ZERO;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (cfg_len != '0) begin
                        len_next   = cfg_len;
                        cnt_next   = '0;
                        state_next = START;
                    end else begin
                        m_data_next = COMPLEX_ZERO;
                        state_next  = HOLD;
                    end
                end
            end
            START: state_next = STREAM;
            STREAM: begin
                if (s_valid) begin
                    acc_in_next = s_data;
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == len_reg - CNT_W'(1))
                        state_next = STOP;
                end
            end
            STOP: begin
                tmr_next   = '0;
                state_next = DRAIN;
            end
            DRAIN: begin
                // A result arriving on the expiry cycle still counts as on time.
                if (acc_valid) begin
                    m_data_next = acc_out;
                    state_next  = HOLD;
                end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            HOLD: begin
                if (m_valid && m_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The accumulator-side outputs are a registered image of the current state,
    // so acc_start/acc_in/acc_stop keep their relative order one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            cnt_reg     <= '0;
            tmr_reg     <= '0;
            acc_start   <= 1'b0;
            acc_stop    <= 1'b0;
            acc_in      <= COMPLEX_ZERO;
            m_valid     <= 1'b0;
            m_data      <= COMPLEX_ZERO;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            tmr_reg     <= tmr_next;
            acc_start   <= (state_reg == START);
            acc_stop    <= (state_reg == STOP);
            acc_in      <= acc_in_next;
            m_valid     <= (state_next == HOLD);
            m_data      <= m_data_next;
            busy        <= (state_next != IDLE);
            err_timeout <= err_next;
        end
    end

endmodule
